// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and the Viterbi decoder chain.
// Keeping the polynomials here guarantees both sides agree on the code.
package conv_pkg;

  localparam int CONV_K = 3;
  localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
  localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } enc_state_t;

  typedef logic [1:0] sym_t;

endpackage

// File: rtl/conv_enc_core.sv
// Combinational parity of a K-bit shift register against the two generator polynomials.
// Bit K-1 of sr is the newest input; also usable as the decoder's expected-symbol generator.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int K = CONV_K,
  parameter logic [K-1:0] G0 = CONV_G0,
  parameter logic [K-1:0] G1 = CONV_G1
) (
  input  logic [K-1:0] sr,
  output logic [1:0]   sym
);

  assign sym = {^(sr & G0), ^(sr & G1)};

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2 convolutional encoder with valid/ready on both sides and K-1 zero tail bits.
// state  | meaning
// IDLE   | waiting for i_start
// ENCODE | accepting FRAME_LEN information bits
// FLUSH  | shifting in K-1 zero tail bits
// DRAIN  | holding the final tail symbol until it is consumed
module conv_encoder
  import conv_pkg::*;
#(
  parameter int K = CONV_K,
  parameter logic [K-1:0] G0 = CONV_G0,
  parameter logic [K-1:0] G1 = CONV_G1,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W = $clog2(FRAME_LEN + K)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       i_start,
  input  logic       i_bit,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [1:0] o_sym,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(K - 2);

  enc_state_t       state;
  logic [K-1:0]     sr;
  logic [K-1:0]     sr_next;
  logic [CNT_W-1:0] cnt;
  logic             slot_free;
  logic             accept;
  logic             xfer;
  logic             shift_in;
  sym_t             sym_next;

  assign slot_free = !o_valid || i_ready;
  assign o_ready   = en && (state == ENCODE) && slot_free;
  assign accept    = i_valid && o_ready;
  assign xfer      = en && o_valid && i_ready;

  // Tail bits are zeros so the decoder's traceback ends in state 0.
  assign shift_in = (state == ENCODE) ? i_bit : 1'b0;
  assign sr_next  = {shift_in, sr[K-1:1]};

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .sr  (sr_next),
    .sym (sym_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      o_sym   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
    end else if (en) begin
      // A consumed symbol retires unless a new one is loaded below in the same cycle.
      if (xfer) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            sr     <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= ENCODE;
          end
        end
        ENCODE: begin
          if (accept) begin
            sr      <= sr_next;
            o_sym   <= sym_next;
            o_valid <= 1'b1;
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= FLUSH;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            sr      <= sr_next;
            o_sym   <= sym_next;
            o_valid <= 1'b1;
            if (cnt == TAIL_LAST) begin
              cnt    <= '0;
              o_last <= 1'b1;
              state  <= DRAIN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder with FRAME_LEN=4: golden table, directed corner sequences and
// randomized frames checked against a time-domain convolution model.
module tb_conv_encoder;

  localparam int K  = 3;
  localparam int FL = 4;
  localparam int TL = FL + K - 1;

  typedef struct {
    logic       b;
    logic [1:0] sym;
    logic       last;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       i_start = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_ready;
  logic [1:0] o_sym;
  logic       o_valid;
  logic       o_last;
  logic       o_busy;

  int total = 0;
  int bad = 0;
  int accepted = 0;

  logic [2:0] xq[$];
  logic [2:0] tg0 = 3'b111;
  logic [2:0] tg1 = 3'b101;
  logic       u_seq[0:TL-1];
  vec_t       gold[0:TL-1];

  always #5 clk = ~clk;

  conv_encoder #(.FRAME_LEN(FL)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i_start (i_start),
    .i_bit   (i_bit),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_sym   (o_sym),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  // Record every symbol that will transfer at the coming rising edge.
  always @(negedge clk)
    if (rst && en && o_valid && i_ready) xq.push_back({o_last, o_sym});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (o_ready && i_valid) accepted++;
    @(posedge clk);
    #1;
  endtask

  // Symbol n of a frame as a convolution over the input sequence u_seq (tail included).
  function automatic logic [2:0] ref_sym(input int n);
    logic g0;
    logic g1;
    g0 = 1'b0;
    g1 = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (n - j >= 0) begin
        if (tg0[K-1-j]) g0 ^= u_seq[n-j];
        if (tg1[K-1-j]) g1 ^= u_seq[n-j];
      end
    end
    return {(n == TL - 1), g0, g1};
  endfunction

  task automatic golden_frame(input int stall_len, input int freeze_len, input bit misuse);
    int st = 0;
    int fz = 0;
    int cyc = 0;
    xq.delete();
    accepted = 0;
    en = 1'b1; i_ready = 1'b1; i_valid = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    while (o_busy && cyc < 60) begin
      cyc++;
      i_valid = (accepted < FL);
      i_bit   = gold[(accepted < FL) ? accepted : 0].b;
      i_ready = 1'b1;
      en      = 1'b1;
      i_start = misuse && (accepted == 1);
      if (accepted == 2 && st < stall_len) begin
        st++;
        i_ready = 1'b0;
        #1;
        chk("stall_ready", o_ready, 0);
        chk("stall_sym", o_sym, 2'b10);
      end else if (accepted == FL && fz < freeze_len) begin
        fz++;
        en = 1'b0;
        #1;
        chk("freeze_ready", o_ready, 0);
        chk("freeze_sym", o_sym, 2'b01);
        chk("freeze_last", o_last, 0);
        chk("freeze_valid", o_valid, 1);
      end
      step();
    end
    i_valid = 1'b0; i_start = 1'b0; en = 1'b1;
    chk("frame_timeout", o_busy, 0);
    chk("frame_accepted", accepted, FL);
    chk("frame_len", xq.size(), TL);
    for (int i = 0; i < TL; i++)
      if (i < xq.size()) chk("frame_sym", xq[i], {gold[i].last, gold[i].sym});
    chk("idle_valid", o_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FL-1:0] data;
    int cyc;

    gold[0] = '{1'b1, 2'b11, 1'b0};
    gold[1] = '{1'b0, 2'b10, 1'b0};
    gold[2] = '{1'b1, 2'b00, 1'b0};
    gold[3] = '{1'b1, 2'b01, 1'b0};
    gold[4] = '{1'b0, 2'b01, 1'b0};
    gold[5] = '{1'b0, 2'b11, 1'b1};

    // Reset dominates start and valid.
    rst = 1'b0; en = 1'b1; i_start = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    step();
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_sym", o_sym, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 0);

    // i_valid in IDLE is neither consumed nor encoded.
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b1; i_bit = 1'b1;
    xq.delete();
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ready", o_ready, 0);
      chk("idle_valid_out", o_valid, 0);
      chk("idle_busy", o_busy, 0);
    end
    chk("idle_accepted", accepted, 0);
    chk("idle_no_sym", xq.size(), 0);
    i_valid = 1'b0;

    // Golden table applied cycle by cycle with i_ready held high.
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < TL; i++) begin
      i_valid = (i < FL);
      i_bit   = gold[i].b;
      step();
      chk("tbl_valid", o_valid, 1);
      chk("tbl_sym", o_sym, gold[i].sym);
      chk("tbl_last", o_last, gold[i].last);
    end
    i_valid = 1'b0;
    chk("tbl_busy_hold", o_busy, 1);
    step();
    chk("tbl_busy_fall", o_busy, 0);
    chk("tbl_valid_fall", o_valid, 0);

    golden_frame(3, 0, 1'b0);
    golden_frame(0, 4, 1'b0);
    golden_frame(0, 0, 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    accepted = 0;
    en = 1'b1; i_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_bit   = gold[i].b;
      step();
    end
    chk("mid_accepted", accepted, 3);
    rst = 1'b0; i_start = 1'b1; i_valid = 1'b1;
    step();
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_sym", o_sym, 0);
    chk("mid_rst_last", o_last, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_ready", o_ready, 0);
    rst = 1'b1; i_start = 1'b0;
    step();
    chk("post_rst_idle", o_busy, 0);
    i_valid = 1'b0;
    golden_frame(0, 0, 1'b0);

    // Randomized frames against the convolution model.
    for (int f = 0; f < 200; f++) begin
      data = FL'($urandom_range(0, (1 << FL) - 1));
      for (int n = 0; n < TL; n++) u_seq[n] = (n < FL) ? data[n] : 1'b0;
      xq.delete();
      accepted = 0;
      en = 1'b1; i_start = 1'b1;
      i_valid = 1'($urandom_range(0, 1));
      i_bit   = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      step();
      i_start = 1'b0;
      cyc = 0;
      while (o_busy && cyc < 400) begin
        cyc++;
        i_valid = ($urandom_range(0, 3) != 0);
        i_bit   = (accepted < FL) ? data[accepted] : 1'($urandom_range(0, 1));
        i_ready = ($urandom_range(0, 3) != 0);
        en      = ($urandom_range(0, 7) != 0);
        i_start = ($urandom_range(0, 15) == 0);
        step();
      end
      en = 1'b1; i_start = 1'b0; i_valid = 1'b0;
      chk("rnd_timeout", o_busy, 0);
      chk("rnd_accepted", accepted, FL);
      chk("rnd_len", xq.size(), TL);
      for (int n = 0; n < TL; n++)
        if (n < xq.size()) chk("rnd_sym", xq[n], ref_sym(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder chain (extract/branch-metric/ACS/memory/traceback under the control FSM). It accepts a framed serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per input bit. After each frame it appends K-1 zero tail bits so the decoder's traceback terminates in state 0. It sits in the test/loopback path that feeds the decoder's symbol input.

Parameters:
K, 3, constraint length; shift register is K bits, with K-1 bits of memory
G0, 3'b111, generator polynomial for o_sym[1] (octal 7); bit K-1 taps the newest input
G1, 3'b101, generator polynomial for o_sym[0] (octal 5)
FRAME_LEN, 16, information bits per frame; must be >= 1
CNT_W, $clog2(FRAME_LEN+K), frame/tail counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
en  in  1  global enable; when 0 all registers hold
i_start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
i_bit  in  1  information bit
i_valid  in  1  i_bit is valid
o_ready  out  1  encoder accepts i_bit this cycle
o_sym  out  2  code symbol {g0, g1}
o_valid  out  1  o_sym is valid
i_ready  in  1  downstream accepts o_sym
o_last  out  1  marks the final tail symbol of a frame; qualified by o_valid
o_busy  out  1  high from accepted i_start until the last symbol is consumed

Behaviour:
- Reset (rst==0 at a clock edge) forces: state=IDLE, shift register=0, counter=0, o_sym=0, o_valid=0, o_last=0, o_busy=0. Reset wins over en and over any handshake, including mid-frame.
- en==0: state, shift register, counter and output register hold. o_ready is forced to 0. o_valid holds its value, but no transfer completes because i_ready is ignored.
- Output slot free: slot_free = !o_valid || i_ready.
- Output transfer: occurs on o_valid && i_ready && en. If no new symbol is loaded in the same cycle, o_valid drops to 0 next cycle.
- FSM states:
  - IDLE: o_ready=0. On i_start && en: clear the shift register, counter=0, o_busy=1, go to ENCODE.
  - ENCODE: o_ready = en && slot_free. On acceptance (i_valid && o_ready):
    - shift register <= {i_bit, sr[K-1:1]}.
    - o_sym <= {^(new_sr & G0), ^(new_sr & G1)}, o_valid <= 1, counter++.
    - When the FRAME_LEN-th bit is accepted: counter=0, go to FLUSH.
  - FLUSH: o_ready=0. Each cycle with en && slot_free, shift in 0 and load the symbol exactly as in ENCODE. On tail bit K-1, set o_last=1 with that symbol and go to DRAIN.
  - DRAIN: wait for the last symbol to transfer. On that transfer: o_valid=0, o_last=0, o_busy=0, go to IDLE.
- Latency: a symbol is valid the cycle after its bit is accepted.
- Throughput: one symbol per cycle with i_ready held high. Back-to-back frames need one IDLE cycle plus an i_start.
- i_start outside IDLE is ignored. i_valid outside ENCODE is ignored and not consumed.
- Back-pressure: while o_valid && !i_ready, o_sym and o_last are stable and no bit is accepted.
- Counter wrap: the counter never exceeds max(FRAME_LEN, K-1)-1; it resets on each state change.

Decomposition:
- Shared package conv_pkg holds:
  - K, G0, G1 defaults, so the decoder's branch-metric unit uses identical polynomials;
  - the FSM enum (IDLE, ENCODE, FLUSH, DRAIN);
  - the 2-bit symbol typedef.
- Natural sub-module: conv_enc_core, combinational parity of the shift register against G0/G1. It is reusable by the decoder's expected-symbol generator.

Test Plan:
- Reset mid-frame: assert rst low after 5 accepted bits -> next cycle all outputs 0, state IDLE. A new i_start then re-encodes from a zero shift register.
- Golden vector: FRAME_LEN=4, input 1,0,1,1 with i_ready=1 -> o_sym 11,10,00,01, then tail 01,11. o_last=1 only on the final 11; o_busy falls after it transfers.
- Back-pressure: during the frame above, hold i_ready=0 for 3 cycles after the 2nd symbol -> o_sym stays 10, o_ready=0, no bit is lost, and the output sequence is unchanged.
- Enable freeze: drop en for 4 cycles during FLUSH -> no state or counter change, o_ready=0. After en returns, the remaining tail symbols 01,11 appear in order.
- Protocol misuse: pulse i_start while busy, and drive i_valid in IDLE -> both ignored, no symbol produced, frame count unaffected.
- Randomised: 200 frames with random data, i_valid and i_ready -> stream matches a reference model. Each frame has exactly FRAME_LEN+K-1 symbols, and the shift register ends at 0.
